// File: rtl/relogio_ajuste_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : relogio_ajuste_ctrl_if
// Description : Signal bundle between the time-set controller and its
//               environment (buttons, 1 Hz tick, counter chain).
//               slave  = controller side, master = environment side.
// Revision    : 1.0  initial release
// ============================================================================
interface relogio_ajuste_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_h_lsd;
  logic [2:0] cur_h_msd;
  logic [3:0] cur_m_lsd;
  logic [2:0] cur_m_msd;
  logic       run_en;
  logic       load;
  logic [3:0] ld_h_lsd;
  logic [2:0] ld_h_msd;
  logic [3:0] ld_m_lsd;
  logic [2:0] ld_m_msd;
  logic [1:0] blink_mask;
  logic [1:0] mode;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    output cur_h_lsd, cur_h_msd, cur_m_lsd, cur_m_msd,
    input  run_en, load, ld_h_lsd, ld_h_msd, ld_m_lsd, ld_m_msd,
    input  blink_mask, mode
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    input  cur_h_lsd, cur_h_msd, cur_m_lsd, cur_m_msd,
    output run_en, load, ld_h_lsd, ld_h_msd, ld_m_lsd, ld_m_msd,
    output blink_mask, mode
  );
endinterface
`default_nettype wire

// File: rtl/relogio_ajuste_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : relogio_ajuste_ctrl
// Description : Time-set controller for an HH:MM:SS clock. Two debounced
//               push-buttons (mode / inc) walk RUN -> SET_H -> SET_M ->
//               COMMIT. COMMIT issues a one-cycle parallel load of the
//               edited hours/minutes; the 1 Hz enable is gated while editing.
//               Idle edits abort back to RUN after TIMEOUT_S seconds.
// Options     : AUTO_REPEAT_EN - holding inc in an edit state auto-repeats
//               after REPEAT_DLY cycles, then every REPEAT_PER cycles.
// Revision    : 1.0  initial release
// ============================================================================
module relogio_ajuste_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned TIMEOUT_S  = 30,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 10000000
) (
  input  wire logic              main_clock,
  input  wire logic              main_reset,
  relogio_ajuste_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_SET_H  = 2'b01;
  localparam logic [1:0] ST_SET_M  = 2'b10;
  localparam logic [1:0] ST_COMMIT = 2'b11;

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);

  // Zero-length timers would make the counters below meaningless.
  if (DEB_CYCLES < 1 || TIMEOUT_S < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
    $error("relogio_ajuste_ctrl: all timing parameters must be >= 1");
  end

  logic [1:0]        r_state;
  logic [3:0]        r_h_lsd;
  logic [2:0]        r_h_msd;
  logic [3:0]        r_m_lsd;
  logic [2:0]        r_m_msd;
  logic [3:0]        r_ld_h_lsd;
  logic [2:0]        r_ld_h_msd;
  logic [3:0]        r_ld_m_lsd;
  logic [2:0]        r_ld_m_msd;
  logic [IDLE_W-1:0] r_idle;
  logic              r_phase;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  logic       w_mode_ev;
  logic       w_inc_ev;
  logic       w_in_edit;
  logic       w_timeout;
  logic [3:0] w_h_lsd_nxt;
  logic [2:0] w_h_msd_nxt;
  logic [3:0] w_m_lsd_nxt;
  logic [2:0] w_m_msd_nxt;

  // Bit 0 = mode button, bit 1 = inc button.
  assign w_btn_raw = {bus.btn_inc, bus.btn_mode};

`ifdef AUTO_REPEAT_EN
  logic w_db_inc;
`endif

  // --------------------------------------------------------------------------
  // Button conditioning: synchronizer, debounce, rising-edge press pulse
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_db_q;
    logic [DEB_W-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge main_clock or negedge main_reset) begin
      if (!main_reset) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_btn_raw[gi];
        r_s2 <= r_s1;
      end
    end

    // Debounced level follows the synchronized level only after it has
    // disagreed for DEB_CYCLES consecutive samples; any bounce restarts.
    always_ff @(posedge main_clock or negedge main_reset) begin
      if (!main_reset) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_cnt <= '0;
        r_db  <= r_s2;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge main_clock or negedge main_reset) begin
      if (!main_reset) begin
        r_db_q <= 1'b0;
      end else begin
        r_db_q <= r_db;
      end
    end

    assign w_press[gi] = r_db & ~r_db_q;

`ifdef AUTO_REPEAT_EN
    if (gi == 1) begin : g_inc_level
      assign w_db_inc = r_db;
    end
`endif
  end

  assign w_in_edit = (r_state == ST_SET_H) || (r_state == ST_SET_M);
  assign w_mode_ev = w_press[0];

`ifdef AUTO_REPEAT_EN
  // --------------------------------------------------------------------------
  // Auto-repeat: extra inc pulses while the debounced inc is held in edit
  // --------------------------------------------------------------------------
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_armed;
  logic             r_rep_pulse;

  // First repeat after REPEAT_DLY held cycles, then every REPEAT_PER cycles.
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else begin
      r_rep_pulse <= 1'b0;
      if (w_db_inc && w_in_edit) begin
        if (!r_rep_armed) begin
          if (r_rep_cnt == REP_W'(REPEAT_DLY - 1)) begin
            r_rep_pulse <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
          end
        end else if (r_rep_cnt == REP_W'(REPEAT_PER - 1)) begin
          r_rep_pulse <= 1'b1;
          r_rep_cnt   <= '0;
        end else begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
      end else begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end
    end
  end

  assign w_inc_ev = w_press[1] | r_rep_pulse;
`else
  assign w_inc_ev = w_press[1];
`endif

  // --------------------------------------------------------------------------
  // BCD successors of the edit registers; illegal codes wrap to 00
  // --------------------------------------------------------------------------
  // Hours: x9 -> (x+1)0, 23 (or anything out of range) -> 00.
  always_comb begin
    w_h_msd_nxt = r_h_msd;
    w_h_lsd_nxt = r_h_lsd + 4'd1;
    if (r_h_msd > 3'd2 || r_h_lsd > 4'd9 || (r_h_msd == 3'd2 && r_h_lsd >= 4'd3)) begin
      w_h_msd_nxt = 3'd0;
      w_h_lsd_nxt = 4'd0;
    end else if (r_h_lsd == 4'd9) begin
      w_h_msd_nxt = r_h_msd + 3'd1;
      w_h_lsd_nxt = 4'd0;
    end
  end

  // Minutes: x9 -> (x+1)0, 59 (or anything out of range) -> 00, no carry.
  always_comb begin
    w_m_msd_nxt = r_m_msd;
    w_m_lsd_nxt = r_m_lsd + 4'd1;
    if (r_m_msd > 3'd5 || r_m_lsd > 4'd9 || (r_m_msd == 3'd5 && r_m_lsd == 4'd9)) begin
      w_m_msd_nxt = 3'd0;
      w_m_lsd_nxt = 4'd0;
    end else if (r_m_lsd == 4'd9) begin
      w_m_msd_nxt = r_m_msd + 3'd1;
      w_m_lsd_nxt = 4'd0;
    end
  end

  // Abort fires on the tick that completes TIMEOUT_S idle seconds; a press
  // in the same cycle counts as activity and wins.
  assign w_timeout = w_in_edit && bus.tick_1hz && !w_mode_ev && !w_inc_ev &&
                     (r_idle == IDLE_W'(TIMEOUT_S - 1));

  // --------------------------------------------------------------------------
  // Main FSM with edit and load registers
  // --------------------------------------------------------------------------
  // Mode press always takes priority over a same-cycle inc press.
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_state    <= ST_RUN;
      r_h_lsd    <= 4'd0;
      r_h_msd    <= 3'd0;
      r_m_lsd    <= 4'd0;
      r_m_msd    <= 3'd0;
      r_ld_h_lsd <= 4'd0;
      r_ld_h_msd <= 3'd0;
      r_ld_m_lsd <= 4'd0;
      r_ld_m_msd <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mode_ev) begin
            r_h_lsd <= bus.cur_h_lsd;
            r_h_msd <= bus.cur_h_msd;
            r_m_lsd <= bus.cur_m_lsd;
            r_m_msd <= bus.cur_m_msd;
            r_state <= ST_SET_H;
          end
        end
        ST_SET_H: begin
          if (w_mode_ev) begin
            r_state <= ST_SET_M;
          end else if (w_timeout) begin
            r_state <= ST_RUN;
          end else if (w_inc_ev) begin
            r_h_lsd <= w_h_lsd_nxt;
            r_h_msd <= w_h_msd_nxt;
          end
        end
        ST_SET_M: begin
          if (w_mode_ev) begin
            r_ld_h_lsd <= r_h_lsd;
            r_ld_h_msd <= r_h_msd;
            r_ld_m_lsd <= r_m_lsd;
            r_ld_m_msd <= r_m_msd;
            r_state    <= ST_COMMIT;
          end else if (w_timeout) begin
            r_state <= ST_RUN;
          end else if (w_inc_ev) begin
            r_m_lsd <= w_m_lsd_nxt;
            r_m_msd <= w_m_msd_nxt;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Idle-second counter: runs on ticks in edit, cleared by any activity.
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_idle <= '0;
    end else if (!w_in_edit || w_mode_ev || w_inc_ev || w_timeout) begin
      r_idle <= '0;
    end else if (bus.tick_1hz) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Blink phase: toggles each second in edit, restarts at 0 on state entry.
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_phase <= 1'b0;
    end else if (!w_in_edit || w_mode_ev) begin
      r_phase <= 1'b0;
    end else if (bus.tick_1hz) begin
      r_phase <= ~r_phase;
    end
  end

  assign bus.mode       = r_state;
  assign bus.run_en     = (r_state == ST_RUN);
  assign bus.load       = (r_state == ST_COMMIT);
  assign bus.ld_h_lsd   = r_ld_h_lsd;
  assign bus.ld_h_msd   = r_ld_h_msd;
  assign bus.ld_m_lsd   = r_ld_m_lsd;
  assign bus.ld_m_msd   = r_ld_m_msd;
  assign bus.blink_mask = {r_phase & (r_state == ST_SET_H),
                           r_phase & (r_state == ST_SET_M)};

endmodule
`default_nettype wire

// File: tb/tb_relogio_ajuste_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_relogio_ajuste_ctrl
// Description : Self-checking bench for relogio_ajuste_ctrl. A behavioural
//               model (integer hours/minutes, raw-sample window debounce)
//               is compared against the DUT every cycle; directed scenarios
//               add literal expectations. Honours AUTO_REPEAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_relogio_ajuste_ctrl;
  localparam int DEB  = 4;
  localparam int TMO  = 3;
  localparam int RDLY = 20;
  localparam int RPER = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relogio_ajuste_ctrl_if bus();

  relogio_ajuste_ctrl #(
    .DEB_CYCLES(DEB), .TIMEOUT_S(TMO), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .main_clock(clk),
    .main_reset(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int m_state;          // 0 RUN, 1 SET_H, 2 SET_M, 3 COMMIT
  int m_eh, m_em;       // edit hours / minutes as integers
  int m_ldh, m_ldm;     // last committed values
  int m_idle;
  bit m_phase;
  bit m_db   [2];
  bit m_pend [2];       // press detected, acted on at the next edge
  bit m_hist [2][DEB+2];
  int m_hold;
  bit m_rep_pend;

  int n_loads = 0;
  int seen_ldh = 0, seen_ldm = 0;

  function automatic void model_reset();
    m_state = 0; m_eh = 0; m_em = 0; m_ldh = 0; m_ldm = 0;
    m_idle = 0; m_phase = 0; m_hold = 0; m_rep_pend = 0;
    for (int b = 0; b < 2; b++) begin
      m_db[b] = 0; m_pend[b] = 0;
      for (int i = 0; i < DEB + 2; i++) m_hist[b][i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit raw [2];
    bit mp, ip, tk, all_new;
    raw[0] = bus.btn_mode;
    raw[1] = bus.btn_inc;
    tk = bus.tick_1hz;
    mp = m_pend[0];
    ip = m_pend[1];
`ifdef AUTO_REPEAT_EN
    ip = ip | m_rep_pend;
    if (m_db[1] && (m_state == 1 || m_state == 2)) begin
      m_hold++;
      m_rep_pend = (m_hold >= RDLY) && (((m_hold - RDLY) % RPER) == 0);
    end else begin
      m_hold = 0;
      m_rep_pend = 0;
    end
`endif
    // A button registers once the raw samples taken 2..DEB+1 edges ago all agree.
    for (int b = 0; b < 2; b++) begin
      for (int i = DEB + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
      all_new = 1;
      for (int i = 2; i < DEB + 2; i++) if (m_hist[b][i] == m_db[b]) all_new = 0;
      m_pend[b] = all_new && !m_db[b];
      if (all_new) m_db[b] = !m_db[b];
    end
    case (m_state)
      0: if (mp) begin
           m_eh = bus.cur_h_msd * 10 + bus.cur_h_lsd;
           m_em = bus.cur_m_msd * 10 + bus.cur_m_lsd;
           m_state = 1; m_idle = 0; m_phase = 0;
         end
      1, 2: begin
        if (mp) begin
          if (m_state == 1) m_state = 2;
          else begin m_state = 3; m_ldh = m_eh; m_ldm = m_em; end
          m_idle = 0; m_phase = 0;
        end else begin
          if (ip) begin
            if (m_state == 1) m_eh = (m_eh >= 23) ? 0 : m_eh + 1;
            else              m_em = (m_em >= 59) ? 0 : m_em + 1;
            m_idle = 0;
          end else if (tk) m_idle++;
          if (tk) m_phase = !m_phase;
          if (m_idle >= TMO) begin m_state = 0; m_idle = 0; end
        end
      end
      default: m_state = 0;
    endcase
  endfunction

  function automatic void check();
    logic [19:0] act, exp;
    logic [1:0]  st;
    st  = m_state[1:0];
    act = {bus.mode, bus.run_en, bus.load, bus.blink_mask,
           bus.ld_h_msd, bus.ld_h_lsd, bus.ld_m_msd, bus.ld_m_lsd};
    exp = {st, (m_state == 0), (m_state == 3),
           (m_phase && m_state == 1), (m_phase && m_state == 2),
           3'(m_ldh / 10), 4'(m_ldh % 10), 3'(m_ldm / 10), 4'(m_ldm % 10)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act, exp);
    end
    if (bus.load === 1'b1) begin
      n_loads++;
      seen_ldh = bus.ld_h_msd * 10 + bus.ld_h_lsd;
      seen_ldm = bus.ld_m_msd * 10 + bus.ld_m_lsd;
    end
  endfunction

  function automatic void lit(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1 check();
  endtask

  task automatic press(input bit m, input bit i);
    bus.btn_mode = m; bus.btn_inc = i;
    repeat (DEB + 3) step();
    bus.btn_mode = 0; bus.btn_inc = 0;
    repeat (DEB + 3) step();
  endtask

  task automatic tick();
    bus.tick_1hz = 1; step();
    bus.tick_1hz = 0; step();
  endtask

  task automatic set_cur(input int h, input int m);
    bus.cur_h_msd = 3'(h / 10); bus.cur_h_lsd = 4'(h % 10);
    bus.cur_m_msd = 3'(m / 10); bus.cur_m_lsd = 4'(m % 10);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1 check();
    repeat (3) step();
    rst_n = 1;
  endtask

  initial begin
    int loads0, exp_m;
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_inc = 0;
    set_cur(12, 34);
    model_reset();

    // 1. reset
    do_reset();
    repeat (5) step();
    lit("reset_mode", bus.mode, 0);
    lit("reset_run_en", bus.run_en, 1);
    lit("reset_blink", bus.blink_mask, 0);

    // 2. full edit 12:34 -> 15:36
    press(1, 0);
    lit("enter_set_h", bus.mode, 1);
    lit("run_en_gated", bus.run_en, 0);
    repeat (3) press(0, 1);
    press(1, 0);
    lit("enter_set_m", bus.mode, 2);
    repeat (2) press(0, 1);
    press(1, 0);
    lit("commit_loads", n_loads, 1);
    lit("commit_ld_h", seen_ldh, 15);
    lit("commit_ld_m", seen_ldm, 36);
    lit("model_ld_h", m_ldh, 15);
    lit("back_to_run", bus.mode, 0);

    // 3. wrap 23:59 -> 00:00
    set_cur(23, 59);
    press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
    lit("wrap_loads", n_loads, 2);
    lit("wrap_ld_h", seen_ldh, 0);
    lit("wrap_ld_m", seen_ldm, 0);

    // 4. glitch, then same-cycle mode+inc in SET_H
    set_cur(7, 45);
    bus.btn_mode = 1; repeat (3) step(); bus.btn_mode = 0;
    repeat (10) step();
    lit("glitch_ignored", bus.mode, 0);
    press(1, 0);
    press(1, 1);
    lit("simul_to_set_m", bus.mode, 2);
    press(1, 0);
    lit("simul_ld_h", seen_ldh, 7);
    lit("simul_ld_m", seen_ldm, 45);

    // 5. timeout in SET_M, reset in SET_H
    loads0 = n_loads;
    press(1, 0); press(1, 0);
    tick(); tick();
    lit("pre_timeout", bus.mode, 2);
    tick();
    lit("timeout_mode", bus.mode, 0);
    lit("timeout_run_en", bus.run_en, 1);
    lit("timeout_no_load", n_loads, loads0);
    press(1, 0);
    do_reset();
    lit("reset_mid_mode", bus.mode, 0);
    lit("reset_mid_load", n_loads, loads0);
    repeat (5) step();

    // 6. held inc in SET_M from :10
    set_cur(12, 10);
    press(1, 0); press(1, 0);
    bus.btn_inc = 1; repeat (45) step(); bus.btn_inc = 0;
    repeat (DEB + 3) step();
    press(1, 0);
`ifdef AUTO_REPEAT_EN
    exp_m = 14;
`else
    exp_m = 11;
`endif
    lit("hold_inc_ld_m", seen_ldm, exp_m);

    // 7. randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(0, 7) == 0) bus.btn_inc = ~bus.btn_inc;
      bus.tick_1hz = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      if ($urandom_range(0, 1499) == 0) do_reset();
      step();
    end
    bus.tick_1hz = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
